adder_arbiter: RTL and testbench

//  Shares one combinational simpleAdder (N-bit: a, b -> S, carry, overflow) among NREQ requesters.

---
 rtl/adder_arbiter.sv | 143 ++++++++++++++
 tb/tb_adder_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin front end that shares one external simpleAdder among NREQ requesters.
// Optional feature: define ADDER_ARB_OVF_CNT_EN to add the saturating ovf_count output.
module adder_arbiter #(
  parameter int  N    = 32,
  parameter int  NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic [N-1:0]      add_a,
  output logic [N-1:0]      add_b,
  input  logic [N-1:0]      add_s,
  input  logic              add_carry,
  input  logic              add_overflow,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [N-1:0]      rsp_sum,
  output logic              rsp_carry,
  output logic              rsp_overflow,
`ifdef ADDER_ARB_OVF_CNT_EN
  output logic [15:0]       ovf_count,
`endif
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t          state_reg;
  logic [IDW-1:0]  last_id_reg;
  logic [IDW-1:0]  id_reg;
  logic [N-1:0]    a_reg;
  logic [N-1:0]    b_reg;
  logic            rsp_valid_reg;
  logic [IDW-1:0]  rsp_id_reg;
  logic [N-1:0]    rsp_sum_reg;
  logic            rsp_carry_reg;
  logic            rsp_overflow_reg;

  logic [N-1:0]    a_arr [NREQ];
  logic [N-1:0]    b_arr [NREQ];
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic            found;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign a_arr[gi] = req_a[gi*N +: N];
      assign b_arr[gi] = req_b[gi*N +: N];
    end
  endgenerate

  // Search starts just after the last winner and wraps, giving round-robin fairness.
  always_comb begin
    logic [IDW-1:0] idx;
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(last_id_reg) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = idx;
      end
    end
  end

  assign req_ready = (state_reg == IDLE && !rst) ? grant : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      last_id_reg      <= IDW'(NREQ - 1);
      id_reg           <= '0;
      a_reg            <= '0;
      b_reg            <= '0;
      rsp_valid_reg    <= 1'b0;
      rsp_id_reg       <= '0;
      rsp_sum_reg      <= '0;
      rsp_carry_reg    <= 1'b0;
      rsp_overflow_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|(req_valid & req_ready)) begin
            a_reg       <= a_arr[grant_id];
            b_reg       <= b_arr[grant_id];
            id_reg      <= grant_id;
            last_id_reg <= grant_id;
            state_reg   <= ISSUE;
          end
        end
        ISSUE: begin
          // The external adder has seen the latched operands for a full cycle.
          rsp_sum_reg      <= add_s;
          rsp_carry_reg    <= add_carry;
          rsp_overflow_reg <= add_overflow;
          rsp_id_reg       <= id_reg;
          rsp_valid_reg    <= 1'b1;
          state_reg        <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign add_a        = a_reg;
  assign add_b        = b_reg;
  assign rsp_valid    = rsp_valid_reg;
  assign rsp_id       = rsp_id_reg;
  assign rsp_sum      = rsp_sum_reg;
  assign rsp_carry    = rsp_carry_reg;
  assign rsp_overflow = rsp_overflow_reg;
  assign busy         = (state_reg != IDLE);

`ifdef ADDER_ARB_OVF_CNT_EN
  logic [15:0] ovf_count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_count_reg <= '0;
    end else if (rsp_valid_reg && rsp_ready && rsp_overflow_reg && ovf_count_reg != 16'hFFFF) begin
      ovf_count_reg <= ovf_count_reg + 16'd1;
    end
  end

  assign ovf_count = ovf_count_reg;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: randomized + directed stimulus with a queue scoreboard and round-robin reference model.
// A behavioural stand-in for the external simpleAdder closes the add_* loop.
module tb_adder_arbiter;
  localparam int N    = 32;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [N-1:0]      add_a;
  logic [N-1:0]      add_b;
  logic [N-1:0]      add_s;
  logic              add_carry;
  logic              add_overflow;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [N-1:0]      rsp_sum;
  logic              rsp_carry;
  logic              rsp_overflow;
  logic              busy;
`ifdef ADDER_ARB_OVF_CNT_EN
  logic [15:0]       ovf_count;
`endif

  always #5 clk = ~clk;

  adder_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .add_a(add_a), .add_b(add_b), .add_s(add_s), .add_carry(add_carry), .add_overflow(add_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_carry(rsp_carry), .rsp_overflow(rsp_overflow),
`ifdef ADDER_ARB_OVF_CNT_EN
    .ovf_count(ovf_count),
`endif
    .busy(busy)
  );

  // External simpleAdder stand-in
  assign {add_carry, add_s} = {1'b0, add_a} + {1'b0, add_b};
  assign add_overflow = (add_a[N-1] == add_b[N-1]) && (add_s[N-1] != add_a[N-1]);

  typedef struct {
    int          id;
    logic [31:0] s;
    logic        c;
    logic        o;
  } exp_t;

  exp_t        exp_q [$];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          cycle = 0;
  int          grant_cnt [NREQ] = '{default: 0};
  int          seen_cnt  [NREQ] = '{default: 0};
  int          ovf_force_cnt = 0;
  bit          rearm = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
  endtask

  // ---------------- monitor / reference model ----------------
  int          model_last = NREQ - 1;
  bit          inflight = 1'b0;
  bit          rsp_seen = 1'b0;
  bit          rst_prev = 1'b0;
  int          hs_cycle = 0;
  logic [15:0] model_ovf = 16'd0;
  int          ovf_force_seen = 0;

  always @(negedge clk) begin
    logic [NREQ-1:0] exp_rdy;
    int              win;
    int              idx;
    bit              busy_before;
    exp_t            e;
    logic [31:0]     oa, ob;
    longint          usum, ssum, lim;
    cycle++;
    if (rst) begin
      if (rst_prev) begin
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_fields", {rsp_id, rsp_carry, rsp_overflow, rsp_sum}, 0);
        chk("rst_add_ops", {add_a, add_b}, 0);
`ifdef ADDER_ARB_OVF_CNT_EN
        chk("rst_ovf_count", ovf_count, 0);
`endif
      end
      exp_q.delete();
      inflight   = 1'b0;
      rsp_seen   = 1'b0;
      model_last = NREQ - 1;
      model_ovf  = 16'd0;
      rst_prev   = 1'b1;
    end else begin
      rst_prev    = 1'b0;
      busy_before = inflight;
`ifdef ADDER_ARB_OVF_CNT_EN
      if (ovf_force_cnt != ovf_force_seen) begin
        ovf_force_seen = ovf_force_cnt;
        model_ovf      = 16'hFFFF;
      end
      chk("ovf_count", ovf_count, model_ovf);
`endif
      // response side
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", rsp_valid, 0);
        end else begin
          e = exp_q[0];
          chk("rsp_id", rsp_id, e.id);
          chk("rsp_sum", rsp_sum, e.s);
          chk("rsp_carry", rsp_carry, e.c);
          chk("rsp_overflow", rsp_overflow, e.o);
          if (!rsp_seen) begin
            chk("rsp_latency", cycle - hs_cycle, 2);
            rsp_seen = 1'b1;
          end
          if (rsp_ready) begin
            $display("txn id=%0d sum=%08h carry=%0b ovf=%0b cycle=%0d", e.id, e.s, e.c, e.o, cycle);
            void'(exp_q.pop_front());
            inflight = 1'b0;
            rsp_seen = 1'b0;
            if (e.o && model_ovf != 16'hFFFF) model_ovf = model_ovf + 16'd1;
          end
        end
      end else if (inflight && (cycle - hs_cycle) >= 2) begin
        chk("rsp_valid_held", rsp_valid, 1);
        exp_q.delete();
        inflight = 1'b0;
        rsp_seen = 1'b0;
      end
      // grant side: first valid requester after the previous winner, only while nothing is in flight
      exp_rdy = '0;
      win     = -1;
      if (!busy_before) begin
        for (int k = 1; k <= NREQ; k++) begin
          idx = (model_last + k) % NREQ;
          if (win < 0 && req_valid[idx]) win = idx;
        end
      end
      if (win >= 0) exp_rdy[win] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);
      chk("busy", busy, busy_before);
      if (win >= 0) begin
        oa   = req_a[win*N +: N];
        ob   = req_b[win*N +: N];
        usum = longint'({32'd0, oa}) + longint'({32'd0, ob});
        ssum = longint'($signed(oa)) + longint'($signed(ob));
        lim  = 64'sh8000_0000;
        e.id = win;
        e.s  = usum[31:0];
        e.c  = usum[32];
        e.o  = (ssum >= lim) || (ssum < -lim);
        exp_q.push_back(e);
        model_last = win;
        inflight   = 1'b1;
        hs_cycle   = cycle;
        grant_cnt[win]++;
      end
    end
  end

  // ---------------- driver ----------------
  function automatic logic [31:0] rand_op();
    case ($urandom % 6)
      0: rand_op = 32'h0000_0000;
      1: rand_op = 32'hFFFF_FFFF;
      2: rand_op = 32'h7FFF_FFFF;
      3: rand_op = 32'h8000_0000;
      default: rand_op = $urandom;
    endcase
  endfunction

  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*N +: N] = a;
    req_b[i*N +: N] = b;
    req_valid[i]    = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_cnt[i] != seen_cnt[i]) begin
        seen_cnt[i] = grant_cnt[i];
        if (rearm) issue(i, rand_op(), rand_op());
        else req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic give_up(input string what);
    $display("FAIL %s: timed out at cycle %0d", what, cycle);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt + 1);
    $fatal(1, "bench stopped");
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      tick();
      n++;
    end while ((req_valid != '0 || busy || rsp_valid) && n < budget);
    if (req_valid != '0 || busy || rsp_valid) give_up("wait_idle");
  endtask

  function automatic int total_grants();
    int t = 0;
    for (int i = 0; i < NREQ; i++) t += grant_cnt[i];
    return t;
  endfunction

  initial begin
    int g0;
    int n;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    rst       = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // only req 2, carry and overflow both set
    issue(2, 32'hAFFF_FFFF, 32'hAFFF_FFFF);
    wait_idle(50);

    // only req 1, signed overflow without carry, consumer stalls 5 cycles
    rsp_ready = 1'b0;
    issue(1, 32'h7FFF_FFFF, 32'h0000_0001);
    n = 0;
    do begin tick(); n++; end while (!rsp_valid && n < 20);
    if (!rsp_valid) give_up("wait_rsp");
    repeat (5) tick();
    rsp_ready = 1'b1;
    wait_idle(50);

    // req 3 wraps to zero, then req 0 and 3 together: 0 wins after 3
    issue(3, 32'hFFFF_FFFF, 32'h0000_0001);
    wait_idle(50);
    issue(0, rand_op(), rand_op());
    issue(3, rand_op(), rand_op());
    wait_idle(50);

`ifdef ADDER_ARB_OVF_CNT_EN
    tick();
    force dut.ovf_count_reg = 16'hFFFF;
    ovf_force_cnt++;
    tick();
    release dut.ovf_count_reg;
    issue(1, 32'h7FFF_FFFF, 32'h0000_0001);
    wait_idle(50);
`endif

    // reset while the transaction is in ISSUE: it must vanish
    issue(2, rand_op(), rand_op());
    n = 0;
    do begin tick(); n++; end while (req_valid[2] && n < 20);
    if (req_valid[2]) give_up("wait_grant");
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    wait_idle(20);

    // all four continuously valid from reset: 0,1,2,3,0
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) issue(i, rand_op(), rand_op());
    rearm = 1'b1;
    g0 = total_grants();
    n  = 0;
    while (total_grants() - g0 < 5 && n < 100) begin tick(); n++; end
    rearm = 1'b0;
    wait_idle(100);

    // randomized traffic with random back-pressure
    repeat (400) begin
      tick();
      rsp_ready = ($urandom % 4) != 0;
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i] && ($urandom % 3) == 0) issue(i, rand_op(), rand_op());
    end
    rsp_ready = 1'b1;
    wait_idle(200);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cycle);
    $fatal(1, "watchdog");
  end

endmodule
